// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Optional feature macro: CLKDIV_PERIOD_CNT_EN (adds a period counter output).
package clkdiv_pkg;

   // Controller states: IDLE (stopped), RUN (counting), PEND (divisor queued),
   // STOP (finishing the current period before halting).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2,
      STOP = 2'd3
   } state_e;

   // Smallest divisor that still yields both a high and a low phase.
   localparam int DIV_MIN = 2;

   // High-phase length for a divisor: odd divisors get the extra cycle high.
   function automatic logic [31:0] half_of(input logic [31:0] div);
      return (div + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clkdiv_phase_gen.sv
// Phase counter for the clock divider: counts 0..div-1, derives the registered
// divided clock and the rising-edge tick, and owns the active divisor.
// The divisor only changes on load_i, which the controller asserts either in
// IDLE or on the wrap cycle, so the waveform never gets a truncated phase.
// Optional feature macro: CLKDIV_PERIOD_CNT_EN (handled in clkdiv_ctrl).
module clkdiv_phase_gen
   import clkdiv_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             active_i,    // controller is currently in a counting state
   input  logic             run_next_i,  // controller will be in a counting state next cycle
   input  logic             load_i,      // replace the active divisor this cycle
   input  logic [DIV_W-1:0] load_div_i,
   output logic             wrap_o,      // last cycle of the current period
   output logic [DIV_W-1:0] div_o,
   output logic             clk_out_o,
   output logic             tick_o
);

   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             wrap;

   function automatic logic [DIV_W-1:0] half_w(input logic [DIV_W-1:0] d);
      return DIV_W'(half_of(32'(d)));
   endfunction

   assign wrap = active_i && (cnt_q == (div_q - ONE));

   // Next counter, divisor and output levels; outputs follow the next count
   // so that clk_out and tick are plain registers.
   always_comb begin
      div_d = div_q;
      if (load_i) begin
         div_d = load_div_i;
      end
      cnt_d = '0;
      if (active_i && run_next_i && !wrap) begin
         cnt_d = cnt_q + ONE;
      end
      clk_out_d = run_next_i && (cnt_d < half_w(div_d));
      tick_d    = run_next_i && (cnt_d == '0);
   end

   // Counter, divisor and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         div_q     <= DEF_DIV;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign wrap_o    = wrap;
   assign div_o     = div_q;
   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Programmable integer clock divider with run/stop control and a divisor
// update scheduler. Divisor updates and stop requests both take effect only
// at a period boundary (the wrap cycle), keeping clk_out glitch-free.
// Handshake: a divisor transfers when cfg_valid && cfg_ready; cfg_ready is a
// function of the registered state only, so it never depends on cfg_valid.
// Optional feature macro: CLKDIV_PERIOD_CNT_EN adds period_cnt[15:0].
module clkdiv_ctrl
   import clkdiv_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy
`ifdef CLKDIV_PERIOD_CNT_EN
   ,output logic [15:0]     period_cnt
`endif
);

   localparam logic [DIV_W-1:0] DIV_MIN_W = DIV_W'(DIV_MIN);

   state_e           state_q, state_d;
   logic             pend_vld_q, pend_vld_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             cfg_err_q, cfg_err_d;

   logic             xfer, div_ok, take, active, hold_new, pend_any;
   logic [DIV_W-1:0] pend_val;
   logic             wrap, load, run_next;
   logic [DIV_W-1:0] load_div, div_act;

   // Transfer decode: a legal divisor offered outside IDLE becomes pending;
   // in IDLE it is loaded straight away.
   always_comb begin
      xfer     = cfg_valid && cfg_ready;
      div_ok   = (cfg_div >= DIV_MIN_W);
      take     = xfer && div_ok;
      active   = (state_q != IDLE);
      hold_new = take && active;
      pend_any = pend_vld_q || hold_new;
      pend_val = hold_new ? cfg_div : pend_div_q;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: every counting state resolves run/stop at the wrap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (en) state_d = RUN;
         end
         RUN, PEND: begin
            if (wrap)          state_d = en ? RUN : IDLE;
            else if (!en)      state_d = STOP;
            else if (pend_any) state_d = PEND;
            else               state_d = RUN;
         end
         STOP: begin
            if (wrap) state_d = en ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: ready drops whenever a divisor is already queued.
   always_comb begin
      cfg_ready = (state_q == IDLE) || (state_q == RUN) ||
                  ((state_q == STOP) && !pend_vld_q);
      busy      = (state_q != IDLE);
   end

   // Divisor scheduling: load in IDLE on transfer, otherwise only at wrap.
   always_comb begin
      load       = ((state_q == IDLE) && take) || (wrap && pend_any);
      load_div   = (state_q == IDLE) ? cfg_div : pend_val;
      pend_vld_d = wrap ? 1'b0 : pend_any;
      pend_div_d = pend_val;
      cfg_err_d  = xfer && !div_ok;
      run_next   = (state_d != IDLE);
   end

   // Pending divisor and error pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld_q <= 1'b0;
         pend_div_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_div_q <= pend_div_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   clkdiv_phase_gen #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_phase (
      .clk_i      (clk),
      .rst_i      (rst),
      .active_i   (active),
      .run_next_i (run_next),
      .load_i     (load),
      .load_div_i (load_div),
      .wrap_o     (wrap),
      .div_o      (div_act),
      .clk_out_o  (clk_out),
      .tick_o     (tick)
   );

`ifdef CLKDIV_PERIOD_CNT_EN
   logic [15:0] period_cnt_q;

   // Period counter: counts ticks, restarts whenever the active divisor changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_cnt_q <= '0;
      end else if (load && (load_div != div_act)) begin
         period_cnt_q <= '0;
      end else if (tick) begin
         period_cnt_q <= period_cnt_q + 16'd1;
      end
   end

   assign period_cnt = period_cnt_q;
`else
   // No period counter in this build; div_act is only consumed internally.
   logic unused_div_act;
   assign unused_div_act = ^div_act;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed testbench for clkdiv_ctrl (default DIV_W=8, DEFAULT_DIV=6).
// Optional feature macro: CLKDIV_PERIOD_CNT_EN (period_cnt checked after reset).
module tb_clkdiv_ctrl;

   logic       clk;
   logic       rst;
   logic       en;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_err;
   logic       clk_out;
   logic       tick;
   logic       busy;
`ifdef CLKDIV_PERIOD_CNT_EN
   logic [15:0] period_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   clkdiv_ctrl #(
      .DIV_W       (8),
      .DEFAULT_DIV (6)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy)
`ifdef CLKDIV_PERIOD_CNT_EN
      ,.period_cnt (period_cnt)
`endif
   );

   // Clock and safety timeout.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   // One clock, then settle past the edge before sampling or driving.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (clk_out !== 1'b0)   begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
      checks++; if (tick !== 1'b0)      begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
      checks++; if (cfg_err !== 1'b0)   begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
`ifdef CLKDIV_PERIOD_CNT_EN
      checks++; if (period_cnt !== 16'd0) begin failures++; $display("FAIL reset_period_cnt got=%0d exp=0", period_cnt); end
`endif
   endtask

   task automatic test_default_run;
      logic [11:0] exp_clk;
      logic [11:0] exp_tick;
      exp_clk  = 12'b111000_111000;
      exp_tick = 12'b100000_100000;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++; if (clk_out !== exp_clk[11-i])  begin failures++; $display("FAIL default_clk cyc=%0d got=%b exp=%b", i, clk_out, exp_clk[11-i]); end
         checks++; if (tick !== exp_tick[11-i])    begin failures++; $display("FAIL default_tick cyc=%0d got=%b exp=%b", i, tick, exp_tick[11-i]); end
         checks++; if (busy !== 1'b1)              begin failures++; $display("FAIL default_busy cyc=%0d got=%b exp=1", i, busy); end
      end
   endtask

   task automatic test_idle_cfg;
      logic [9:0] exp_clk;
      logic [8:0] exp_clk3;
      logic [8:0] exp_tick3;
      exp_clk   = 10'b11100_11100;
      exp_clk3  = 9'b110_110_110;
      exp_tick3 = 9'b100_100_100;
      // divisor 5 loaded in IDLE, then start
      do_reset();
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", cfg_ready); end
      cfg_valid = 1'b1;
      cfg_div   = 8'd5;
      step();
      cfg_valid = 1'b0;
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL idle_err got=%b exp=0", cfg_err); end
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (clk_out !== exp_clk[9-i]) begin failures++; $display("FAIL idle5_clk cyc=%0d got=%b exp=%b", i, clk_out, exp_clk[9-i]); end
         checks++; if (cfg_ready !== 1'b1)       begin failures++; $display("FAIL idle5_ready cyc=%0d got=%b exp=1", i, cfg_ready); end
      end
      // en rising together with divisor 3: first period already uses 3
      do_reset();
      en        = 1'b1;
      cfg_valid = 1'b1;
      cfg_div   = 8'd3;
      for (int i = 0; i < 9; i++) begin
         step();
         cfg_valid = 1'b0;
         checks++; if (clk_out !== exp_clk3[8-i]) begin failures++; $display("FAIL same3_clk cyc=%0d got=%b exp=%b", i, clk_out, exp_clk3[8-i]); end
         checks++; if (tick !== exp_tick3[8-i])   begin failures++; $display("FAIL same3_tick cyc=%0d got=%b exp=%b", i, tick, exp_tick3[8-i]); end
      end
   endtask

   task automatic test_pend;
      logic [7:0] exp_clk;
      logic [7:0] exp_tick;
      logic [7:0] exp_rdy;
      exp_clk  = 8'b000_1100_1;
      exp_tick = 8'b000_1000_1;
      exp_rdy  = 8'b000_1111_1;
      do_reset();
      en = 1'b1;
      step(); step(); step();   // now in cnt=2 of N=6
      checks++; if (clk_out !== 1'b1)   begin failures++; $display("FAIL pend_pre_clk got=%b exp=1", clk_out); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL pend_pre_ready got=%b exp=1", cfg_ready); end
      cfg_valid = 1'b1;
      cfg_div   = 8'd4;
      for (int k = 0; k < 8; k++) begin
         step();
         cfg_valid = 1'b0;
         checks++; if (clk_out !== exp_clk[7-k])  begin failures++; $display("FAIL pend_clk cyc=%0d got=%b exp=%b", k, clk_out, exp_clk[7-k]); end
         checks++; if (tick !== exp_tick[7-k])    begin failures++; $display("FAIL pend_tick cyc=%0d got=%b exp=%b", k, tick, exp_tick[7-k]); end
         checks++; if (cfg_ready !== exp_rdy[7-k]) begin failures++; $display("FAIL pend_ready cyc=%0d got=%b exp=%b", k, cfg_ready, exp_rdy[7-k]); end
      end
   endtask

   task automatic test_cfg_err;
      logic [13:0] exp_clk;
      logic [13:0] exp_err;
      exp_clk = 14'b111000_111000_11;
      exp_err = 14'b001100_000000_00;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step();
         checks++; if (clk_out !== exp_clk[13-i]) begin failures++; $display("FAIL err_clk cyc=%0d got=%b exp=%b", i, clk_out, exp_clk[13-i]); end
         checks++; if (cfg_err !== exp_err[13-i]) begin failures++; $display("FAIL err_pulse cyc=%0d got=%b exp=%b", i, cfg_err, exp_err[13-i]); end
         checks++; if (cfg_ready !== 1'b1)        begin failures++; $display("FAIL err_ready cyc=%0d got=%b exp=1", i, cfg_ready); end
         if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd1; end
         if (i == 2) cfg_div = 8'd0;
         if (i == 3) cfg_valid = 1'b0;
      end
   endtask

   task automatic test_stop;
      logic [6:0] exp_clk;
      logic [6:0] exp_busy;
      logic [7:0] exp_clk_r;
      logic [7:0] exp_tick_r;
      exp_clk    = 7'b1000_000;
      exp_busy   = 7'b1111_000;
      exp_clk_r  = 8'b00_111000;
      exp_tick_r = 8'b00_100000;
      // en drops at cnt=1: finish the period then halt
      do_reset();
      en = 1'b1;
      step(); step();
      en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         checks++; if (clk_out !== exp_clk[6-k])  begin failures++; $display("FAIL stop_clk cyc=%0d got=%b exp=%b", k, clk_out, exp_clk[6-k]); end
         checks++; if (busy !== exp_busy[6-k])    begin failures++; $display("FAIL stop_busy cyc=%0d got=%b exp=%b", k, busy, exp_busy[6-k]); end
         checks++; if (tick !== 1'b0)             begin failures++; $display("FAIL stop_tick cyc=%0d got=%b exp=0", k, tick); end
      end
      // en returns during the low phase: next period starts right at the wrap
      do_reset();
      en = 1'b1;
      step(); step();
      en = 1'b0;
      step(); step();           // cnt=3
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         checks++; if (clk_out !== exp_clk_r[7-k])  begin failures++; $display("FAIL resume_clk cyc=%0d got=%b exp=%b", k, clk_out, exp_clk_r[7-k]); end
         checks++; if (tick !== exp_tick_r[7-k])    begin failures++; $display("FAIL resume_tick cyc=%0d got=%b exp=%b", k, tick, exp_tick_r[7-k]); end
         checks++; if (busy !== 1'b1)               begin failures++; $display("FAIL resume_busy cyc=%0d got=%b exp=1", k, busy); end
      end
   endtask

   task automatic test_stop_with_cfg;
      logic [3:0] exp_busy;
      logic [3:0] exp_rdy;
      logic [7:0] exp_clk;
      exp_busy = 4'b1110;
      exp_rdy  = 4'b0001;
      exp_clk  = 8'b1100_1100;
      do_reset();
      en = 1'b1;
      step(); step();           // cnt=1
      en        = 1'b0;
      cfg_valid = 1'b1;
      cfg_div   = 8'd4;
      step();                   // cnt=2, STOP with divisor pending
      cfg_valid = 1'b0;
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL stopcfg_ready got=%b exp=0", cfg_ready); end
      checks++; if (clk_out !== 1'b1)   begin failures++; $display("FAIL stopcfg_clk got=%b exp=1", clk_out); end
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (clk_out !== 1'b0)           begin failures++; $display("FAIL stopcfg_low cyc=%0d got=%b exp=0", k, clk_out); end
         checks++; if (busy !== exp_busy[3-k])     begin failures++; $display("FAIL stopcfg_busy cyc=%0d got=%b exp=%b", k, busy, exp_busy[3-k]); end
         checks++; if (cfg_ready !== exp_rdy[3-k]) begin failures++; $display("FAIL stopcfg_rdy cyc=%0d got=%b exp=%b", k, cfg_ready, exp_rdy[3-k]); end
      end
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         checks++; if (clk_out !== exp_clk[7-k]) begin failures++; $display("FAIL stopcfg_new_clk cyc=%0d got=%b exp=%b", k, clk_out, exp_clk[7-k]); end
      end
   endtask

   task automatic test_reset_mid;
      logic [11:0] exp_clk;
      exp_clk = 12'b111000_111000;
      do_reset();
      cfg_valid = 1'b1;
      cfg_div   = 8'd7;
      step();
      cfg_valid = 1'b0;
      en = 1'b1;
      step(); step(); step();   // cnt=2 of N=7
      checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL rstmid_pre_clk got=%b exp=1", clk_out); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (clk_out !== 1'b0)   begin failures++; $display("FAIL rstmid_clk got=%b exp=0", clk_out); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (tick !== 1'b0)      begin failures++; $display("FAIL rstmid_tick got=%b exp=0", tick); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", cfg_ready); end
`ifdef CLKDIV_PERIOD_CNT_EN
      checks++; if (period_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_period_cnt got=%0d exp=0", period_cnt); end
`endif
      // en still high: restarts with the default divisor of 6
      for (int i = 0; i < 12; i++) begin
         step();
         checks++; if (clk_out !== exp_clk[11-i]) begin failures++; $display("FAIL rstmid_def_clk cyc=%0d got=%b exp=%b", i, clk_out, exp_clk[11-i]); end
      end
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      test_reset();
      test_default_run();
      test_idle_cfg();
      test_pend();
      test_cfg_err();
      test_stop();
      test_stop_with_cfg();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
